// File: rtl/hazard_controller.sv
// Execute-stage hazard controller: tracks EX/WB destination shadows, drives
// operand forward selects, inserts load-use stalls and squashes after taken branches.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] AA,
  input  logic [REG_ADDR_WIDTH-1:0] BA,
  input  logic                      use_a,
  input  logic                      use_b,
  input  logic                      RW_D,
  input  logic [REG_ADDR_WIDTH-1:0] DA_D,
  input  logic [1:0]                MD_D,
  input  logic                      branch_taken,
  output logic                      stall,
  output logic                      bubble,
  output logic                      flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

  // The detect cycle is squashed from RUN, so FLUSH covers the remaining cycles.
  localparam logic [1:0] FLUSH_LOAD = (FLUSH_CYCLES >= 2) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam logic [1:0] MD_MEM     = 2'b01;

  state_t                    state, state_next;
  logic [1:0]                flush_cnt, cnt_next;
  logic                      ex_rw, wb_rw;
  logic [REG_ADDR_WIDTH-1:0] ex_da, wb_da;
  logic [1:0]                ex_md, wb_md;
  logic                      load_hazard;
  logic                      stall_c, bubble_c, flush_c;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] addr,
                                         input logic                      used,
                                         input logic                      e_rw,
                                         input logic [REG_ADDR_WIDTH-1:0] e_da,
                                         input logic [1:0]                e_md,
                                         input logic                      w_rw,
                                         input logic [REG_ADDR_WIDTH-1:0] w_da);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && (addr != '0)) begin
      if (e_rw && (e_da == addr) && (e_md != MD_MEM))
        sel = 2'd1;
      else if (w_rw && (w_da == addr))
        sel = 2'd2;
    end
    return sel;
  endfunction

  assign load_hazard = ex_rw && (ex_md == MD_MEM) && (ex_da != '0) &&
                       ((use_a && (AA == ex_da)) || (use_b && (BA == ex_da)));

  always_comb begin
    state_next = state;
    cnt_next   = flush_cnt;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
          end
        end else if (load_hazard) begin
          stall_c    = 1'b1;
          bubble_c   = 1'b1;
          state_next = LOAD_STALL;
        end
      end
      LOAD_STALL: state_next = RUN;
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (flush_cnt == 2'd0)
          state_next = RUN;
        else
          cnt_next = flush_cnt - 2'd1;
      end
      default: state_next = RUN;
    endcase
  end

  // Gate with rst_n so a branch input cannot leak a flush while held in reset.
  assign stall     = stall_c  & rst_n;
  assign bubble    = bubble_c & rst_n;
  assign flush     = flush_c  & rst_n;
  assign fwd_a_sel = fwd_sel(AA, use_a, ex_rw, ex_da, ex_md, wb_rw, wb_da);
  assign fwd_b_sel = fwd_sel(BA, use_b, ex_rw, ex_da, ex_md, wb_rw, wb_da);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rw <= 1'b0;
      ex_da <= '0;
      ex_md <= 2'b00;
      wb_rw <= 1'b0;
      wb_da <= '0;
      wb_md <= 2'b00;
    end else begin
      wb_rw <= ex_rw;
      wb_da <= ex_da;
      wb_md <= ex_md;
      ex_rw <= bubble_c ? 1'b0 : RW_D;
      ex_da <= DA_D;
      ex_md <= MD_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if ((stall_c || flush_c) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// random instruction streams, compared every cycle against a behavioural model.
module tb_hazard_controller;

  localparam int AW   = 5;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] AA, BA, DA_D;
  logic          use_a, use_b, RW_D, branch_taken;
  logic [1:0]    MD_D;
  logic          stall, bubble, flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles;

  hazard_controller #(.REG_ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .AA(AA), .BA(BA), .use_a(use_a), .use_b(use_b),
    .RW_D(RW_D), .DA_D(DA_D), .MD_D(MD_D), .branch_taken(branch_taken),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the instructions currently in EX and WB write,
  // how many squash cycles remain, and whether the stall's recovery cycle is due.
  int m_ex_rw, m_ex_da, m_ex_md, m_wb_rw, m_wb_da, m_wb_md;
  int m_squash, m_ldstall, m_cnt;
  int e_stall, e_bubble, e_flush, e_fa, e_fb, p_run, p_haz;

  function automatic int exp_fwd(input int x, input int u);
    if (u == 0 || x == 0) return 0;
    if (m_ex_rw != 0 && m_ex_da == x && m_ex_md != 1) return 1;
    if (m_wb_rw != 0 && m_wb_da == x) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex_rw = 0; m_ex_da = 0; m_ex_md = 0;
    m_wb_rw = 0; m_wb_da = 0; m_wb_md = 0;
    m_squash = 0; m_ldstall = 0; m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic predict();
    int a, b;
    a = int'(AA); b = int'(BA);
    p_run = (m_squash == 0 && m_ldstall == 0) ? 1 : 0;
    p_haz = (m_ex_rw != 0 && m_ex_md == 1 && m_ex_da != 0 &&
             ((use_a && a == m_ex_da) || (use_b && b == m_ex_da))) ? 1 : 0;
    e_stall = 0; e_bubble = 0; e_flush = 0;
    if (p_run != 0 && branch_taken) begin
      e_flush = 1; e_bubble = 1;
    end else if (p_run != 0 && p_haz != 0) begin
      e_stall = 1; e_bubble = 1;
    end else if (m_squash > 0) begin
      e_flush = 1; e_bubble = 1;
    end
    e_fa = exp_fwd(a, int'(use_a));
    e_fb = exp_fwd(b, int'(use_b));
  endtask

  task automatic check_outputs(input string ph);
    predict();
    chk({ph, ".stall"},  32'(stall),        32'(e_stall));
    chk({ph, ".bubble"}, 32'(bubble),       32'(e_bubble));
    chk({ph, ".flush"},  32'(flush),        32'(e_flush));
    chk({ph, ".fwd_a"},  32'(fwd_a_sel),    32'(e_fa));
    chk({ph, ".fwd_b"},  32'(fwd_b_sel),    32'(e_fb));
    chk({ph, ".cnt"},    32'(stall_cycles), 32'(m_cnt));
  endtask

  task automatic model_commit();
    if ((e_stall != 0 || e_flush != 0) && m_cnt < CMAX) m_cnt++;
    if (p_run != 0 && branch_taken) m_squash = FC - 1;
    else if (m_squash > 0) m_squash--;
    m_ldstall = (p_run != 0 && !branch_taken && p_haz != 0) ? 1 : 0;
    m_wb_rw = m_ex_rw; m_wb_da = m_ex_da; m_wb_md = m_ex_md;
    m_ex_rw = (e_bubble != 0) ? 0 : int'(RW_D);
    m_ex_da = int'(DA_D);
    m_ex_md = int'(MD_D);
  endtask

  task automatic drive(input int aa, input int ba, input int ua, input int ub,
                       input int rw, input int da, input int md, input int br);
    AA = AW'(aa); BA = AW'(ba); use_a = ua[0]; use_b = ub[0];
    RW_D = rw[0]; DA_D = AW'(da); MD_D = md[1:0]; branch_taken = br[0];
  endtask

  // One pipeline cycle: inputs applied after negedge, outputs checked before posedge.
  task automatic step(input string ph, input int aa, input int ba, input int ua, input int ub,
                      input int rw, input int da, input int md, input int br);
    drive(aa, ba, ua, ub, rw, da, md, br);
    #1;
    check_outputs(ph);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string ph);
    chk({ph, ".stall"},  32'(stall),        32'd0);
    chk({ph, ".bubble"}, 32'(bubble),       32'd0);
    chk({ph, ".flush"},  32'(flush),        32'd0);
    chk({ph, ".fwd_a"},  32'(fwd_a_sel),    32'd0);
    chk({ph, ".fwd_b"},  32'(fwd_b_sel),    32'd0);
    chk({ph, ".cnt"},    32'(stall_cycles), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    drive(5, 5, 1, 1, 1, 5, 0, 0);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU result forwarded from EX, then from WB
    step("ex_alu_wr",  0, 0, 0, 0, 1, 5, 0, 0);
    step("ex_fwd_a",   5, 0, 1, 0, 0, 0, 0, 0);
    step("wb_fwd_b",   0, 5, 0, 1, 0, 0, 0, 0);
    // EX beats WB when both write the same register
    step("both_wr1",   0, 0, 0, 0, 1, 9, 0, 0);
    step("both_wr2",   0, 0, 0, 0, 1, 9, 2, 0);
    step("both_fwd",   9, 9, 1, 1, 0, 0, 0, 0);
    // load-use stall, then the stalled instruction reissues with WB forwarding
    step("load_r7",    0, 0, 0, 0, 1, 7, 1, 0);
    step("lu_stall",   7, 3, 1, 1, 1, 4, 0, 0);
    step("lu_resume",  7, 3, 1, 1, 1, 4, 0, 0);
    step("lu_after",   0, 0, 0, 0, 0, 0, 0, 0);
    // unused operand suppresses hazard and forwarding
    step("load_r6",    0, 0, 0, 0, 1, 6, 1, 0);
    step("unused_op",  6, 6, 0, 0, 0, 0, 0, 0);
    // register 0 never forwards or stalls
    step("r0_load",    0, 0, 0, 0, 1, 0, 1, 0);
    step("r0_alu",     0, 0, 1, 1, 1, 0, 0, 0);
    step("r0_read",    0, 0, 1, 1, 0, 0, 0, 0);
    // branch with simultaneous load hazard, second pulse during flush ignored
    step("br_load",    0, 0, 0, 0, 1, 3, 1, 0);
    step("br_detect",  3, 3, 1, 1, 1, 8, 0, 1);
    step("br_flush2",  3, 3, 1, 1, 1, 8, 0, 1);
    step("br_done",    0, 0, 0, 0, 0, 0, 0, 0);
    step("br_idle",    0, 0, 0, 0, 0, 0, 0, 0);

    // async reset in the middle of a flush
    step("mid_detect", 0, 0, 0, 0, 1, 2, 0, 1);
    drive(2, 2, 1, 1, 0, 0, 0, 0);
    #1;
    check_outputs("mid_flush");
    #2;
    rst_n = 1'b0;
    branch_taken = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",   2, 2, 1, 1, 0, 0, 0, 0);
    step("post_br",    0, 0, 0, 0, 0, 0, 0, 1);
    step("post_br2",   0, 0, 0, 0, 0, 0, 0, 0);

    // random instruction stream over a small register set; counter saturates
    for (int i = 0; i < 400; i++) begin
      step("rand",
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
